// File: rtl/ysyx_24070016_lsu_pkg.sv
// Shared memop codes and FSM state encoding for the load/store unit.
package ysyx_24070016_lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/ysyx_24070016_lsu_if.sv
// EXU request, memory bus and WBU result channels of the LSU.
// master = the LSU itself (drives the bus); slave = the surrounding core and memory.
interface ysyx_24070016_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_wren;
    logic [2:0]  in_memop;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    modport master (
        input  in_valid, in_addr, in_wdata, in_wren, in_memop,
        output in_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output out_valid, out_rdata, out_err,
        input  out_ready
    );

    modport slave (
        output in_valid, in_addr, in_wdata, in_wren, in_memop,
        input  in_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  out_valid, out_rdata, out_err,
        output out_ready
    );
endinterface

// File: rtl/ysyx_24070016_lsu_align.sv
// Combinational lane logic: store strobes/data and error detection on the request side,
// byte/half extraction with sign or zero extension on the response side.
module ysyx_24070016_lsu_align
    import ysyx_24070016_lsu_pkg::*;
(
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_memop,
    input  logic        req_wren,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        err,
    input  logic [1:0]  rsp_off,
    input  logic [2:0]  rsp_memop,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0;
        err   = 1'b0;
        case (req_memop)
            MEMOP_B, MEMOP_BU: begin
                wstrb = 4'b0001 << req_addr[1:0];
                wdata = {4{req_wdata[7:0]}};
            end
            MEMOP_H, MEMOP_HU: begin
                err   = req_addr[0];
                wstrb = 4'b0011 << {req_addr[1], 1'b0};
                wdata = {2{req_wdata[15:0]}};
            end
            MEMOP_W: begin
                err   = |req_addr[1:0];
                wstrb = 4'b1111;
                wdata = req_wdata;
            end
            default: err = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (req_wren && req_memop[2]) err = 1'b1;
        if (!req_wren) begin
            wstrb = 4'b0000;
            wdata = 32'h0;
        end
    end

    assign shifted = rdata >> {rsp_off, 3'b000};

    always_comb begin
        case (rsp_memop)
            MEMOP_B:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            MEMOP_BU: rdata_ext = {24'h0, shifted[7:0]};
            MEMOP_H:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            MEMOP_HU: rdata_ext = {16'h0, shifted[15:0]};
            default:  rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_24070016_lsu.sv
// Single-outstanding RV32I load/store unit: IDLE -> REQ -> WAIT -> DONE, errors skip to DONE.
// All outputs come from registers or state decode; no input-to-output combinational path.
module ysyx_24070016_lsu
    import ysyx_24070016_lsu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ysyx_24070016_lsu_if.master  bus
);

    lsu_state_t  state, next_state;
    logic        in_ready, req_valid, out_valid;

    logic [31:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  memop_q;
    logic        wen_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic        al_err;
    logic [31:0] al_rdata;

    logic        accept;

    ysyx_24070016_lsu_align u_align (
        .req_addr  (bus.in_addr),
        .req_wdata (bus.in_wdata),
        .req_memop (bus.in_memop),
        .req_wren  (bus.in_wren),
        .wstrb     (al_wstrb),
        .wdata     (al_wdata),
        .err       (al_err),
        .rsp_off   (off_q),
        .rsp_memop (memop_q),
        .rdata     (bus.mem_rsp_rdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        req_valid  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) next_state = al_err ? DONE : REQ;
            end
            REQ: begin
                req_valid = 1'b1;
                if (bus.mem_req_ready) next_state = WAIT;
            end
            WAIT: begin
                if (bus.mem_rsp_valid) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 32'h0;
            off_q   <= 2'b00;
            memop_q <= 3'b000;
            wen_q   <= 1'b0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= {bus.in_addr[31:2], 2'b00};
                off_q   <= bus.in_addr[1:0];
                memop_q <= bus.in_memop;
                wen_q   <= bus.in_wren && !al_err;
                wstrb_q <= al_err ? 4'b0000 : al_wstrb;
                wdata_q <= al_err ? 32'h0 : al_wdata;
                rdata_q <= 32'h0;
                err_q   <= al_err;
            end
            // Responses outside WAIT (e.g. after a reset abandoned the access) are dropped.
            if ((state == WAIT) && bus.mem_rsp_valid) begin
                rdata_q <= wen_q ? 32'h0 : al_rdata;
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.mem_req_valid = req_valid;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wstrb     = wstrb_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.out_valid     = out_valid;
    assign bus.out_rdata     = rdata_q;
    assign bus.out_err       = err_q;

endmodule

// File: tb/tb_ysyx_24070016_lsu.sv
// Directed and randomized bench for ysyx_24070016_lsu against a byte-level reference model.
module tb_ysyx_24070016_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    ysyx_24070016_lsu_if bus ();

    ysyx_24070016_lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: access size from memop, legality, per-byte lanes, shift-and-mask extension.
    function automatic void model(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op,
                                  input logic wr, input logic [31:0] rsp,
                                  output logic e, output logic [3:0] st,
                                  output logic [31:0] ln, output logic [31:0] rd);
        logic [31:0] size;
        logic [31:0] off;
        logic [31:0] v;
        size = (op[1:0] == 2'd0) ? 32'd1 : (op[1:0] == 2'd1) ? 32'd2 : 32'd4;
        off  = {30'd0, a[1:0]};
        e    = (op[1:0] == 2'd3) || (op == 3'b110) || (wr && op[2]) || ((a & (size - 1)) != 0);
        st = 4'b0000;
        ln = 32'h0;
        rd = 32'h0;
        if (!e && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) st[i] = 1'b1;
                ln[i*8 +: 8] = wd[(i % size)*8 +: 8];
            end
        end
        if (!e && !wr) begin
            v = rsp >> (8 * off);
            if (size == 1) begin
                v = v & 32'h0000_00FF;
                if (!op[2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'h0000_FFFF;
                if (!op[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            rd = v;
        end
    endfunction

    task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] memop, input logic wren, input logic [31:0] rsp,
                       input int req_stall, input int rsp_delay, input int out_stall);
        logic        e_err;
        logic [3:0]  e_strb;
        logic [31:0] e_lane, e_rd;
        model(addr, wdata, memop, wren, rsp, e_err, e_strb, e_lane, e_rd);
        bus.in_valid = 1'b1;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        bus.in_memop = memop;
        bus.in_wren  = wren;
        check({tag, ".in_ready"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.in_addr  = $urandom;
        bus.in_wdata = $urandom;
        bus.in_memop = 3'($urandom);
        bus.in_wren  = 1'($urandom);
        if (e_err) begin
            check({tag, ".err_vld"}, bus.out_valid, 1);
            check({tag, ".err_req"}, bus.mem_req_valid, 0);
        end else begin
            for (int i = 0; i <= req_stall; i++) begin
                check({tag, ".req_vld"}, bus.mem_req_valid, 1);
                check({tag, ".addr"}, bus.mem_addr, {addr[31:2], 2'b00});
                check({tag, ".wen"}, bus.mem_wen, wren);
                check({tag, ".wstrb"}, bus.mem_wstrb, e_strb);
                if (wren) check({tag, ".wdata"}, bus.mem_wdata, e_lane);
                check({tag, ".busy"}, bus.in_ready, 0);
                if (i == req_stall) bus.mem_req_ready = 1'b1;
                step();
            end
            bus.mem_req_ready = 1'b0;
            for (int i = 0; i < rsp_delay; i++) begin
                check({tag, ".wait_req"}, bus.mem_req_valid, 0);
                check({tag, ".wait_out"}, bus.out_valid, 0);
                step();
            end
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_rdata = rsp;
            step();
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_rdata = $urandom;
            check({tag, ".out_vld"}, bus.out_valid, 1);
        end
        check({tag, ".err"}, bus.out_err, e_err);
        check({tag, ".rdata"}, bus.out_rdata, e_rd);
        for (int i = 0; i < out_stall; i++) begin
            step();
            check({tag, ".hold_vld"}, bus.out_valid, 1);
            check({tag, ".hold_rd"}, bus.out_rdata, e_rd);
            check({tag, ".hold_err"}, bus.out_err, e_err);
            check({tag, ".hold_busy"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, ".out_drop"}, bus.out_valid, 0);
        check({tag, ".idle"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [31:0] ra, rw, rr;
        logic [2:0]  rop;
        logic        rwr;
        bus.in_valid      = 1'b0;
        bus.in_addr       = 32'h0;
        bus.in_wdata      = 32'h0;
        bus.in_wren       = 1'b0;
        bus.in_memop      = 3'b000;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;
        bus.out_ready     = 1'b0;
        step();
        step();
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.req_vld", bus.mem_req_valid, 0);
        check("rst.addr", bus.mem_addr, 0);
        check("rst.wen", bus.mem_wen, 0);
        check("rst.wstrb", bus.mem_wstrb, 0);
        check("rst.wdata", bus.mem_wdata, 0);
        check("rst.out_vld", bus.out_valid, 0);
        check("rst.rdata", bus.out_rdata, 0);
        check("rst.err", bus.out_err, 0);
        rst = 1'b0;
        step();

        txn("sb",  32'h8000_0003, 32'h1234_56AB, 3'b000, 1'b1, 32'h0,        0, 0, 0);
        txn("lb",  32'h8000_0001, 32'h0,         3'b000, 1'b0, 32'h0000_8000, 0, 0, 0);
        txn("lbu", 32'h8000_0001, 32'h0,         3'b100, 1'b0, 32'h0000_8000, 0, 0, 0);
        txn("lh",  32'h8000_0002, 32'h0,         3'b001, 1'b0, 32'h8765_0000, 0, 0, 0);
        txn("lhu", 32'h8000_0002, 32'h0,         3'b101, 1'b0, 32'h8765_0000, 0, 0, 0);
        txn("lw_mis", 32'h8000_0002, 32'h0,      3'b010, 1'b0, 32'h0,         0, 0, 0);
        txn("op011", 32'h8000_0000, 32'h0,       3'b011, 1'b0, 32'h0,         0, 0, 0);
        txn("sbu_ill", 32'h8000_0000, 32'h5,     3'b100, 1'b1, 32'h0,         0, 0, 0);
        txn("sh_hi", 32'h8000_0002, 32'hCAFE_BEEF, 3'b001, 1'b1, 32'h0,       0, 1, 0);
        txn("stall", 32'h1000_0004, 32'hDEAD_BEEF, 3'b010, 1'b1, 32'h0,       3, 0, 2);
        txn("lw_stall", 32'h1000_0008, 32'h0,    3'b010, 1'b0, 32'h1357_9BDF, 3, 2, 2);

        // Reset in WAIT, then a stray response that must be ignored.
        bus.in_valid = 1'b1;
        bus.in_addr  = 32'h8000_0004;
        bus.in_memop = 3'b010;
        bus.in_wren  = 1'b0;
        step();
        bus.in_valid      = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        check("rstw.pre_out", bus.out_valid, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw.in_ready", bus.in_ready, 1);
        check("rstw.req_vld", bus.mem_req_valid, 0);
        check("rstw.out_vld", bus.out_valid, 0);
        check("rstw.addr", bus.mem_addr, 0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'hFFFF_FFFF;
        step();
        bus.mem_rsp_valid = 1'b0;
        check("stray.out_vld", bus.out_valid, 0);
        check("stray.rdata", bus.out_rdata, 0);
        step();
        check("stray.out_vld2", bus.out_valid, 0);
        check("stray.in_ready", bus.in_ready, 1);
        txn("sw_after", 32'h8000_0010, 32'h0BAD_F00D, 3'b010, 1'b1, 32'h0, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            ra  = $urandom;
            rw  = $urandom;
            rr  = $urandom;
            rop = 3'($urandom_range(0, 7));
            rwr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            txn("rand", ra, rw, rop, rwr, rr,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
